// File: rtl/jtag_shift_master.sv
// JTAG shift master: runs TAP reset, IR scan and DR scan commands on a divided TCK,
// capturing TDO into a response word. Commands and responses use valid/ready handshakes.
module jtag_shift_master #(
  parameter int CLK_DIV = 2,
  parameter int MAX_LEN = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [1:0]         cmd_type_i,
  input  logic [6:0]         cmd_len_i,
  input  logic [MAX_LEN-1:0] cmd_data_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [MAX_LEN-1:0] rsp_data_o,
  output logic               rsp_err_o,
  output logic               jtag_tck_o,
  output logic               jtag_tms_o,
  output logic               jtag_tdi_o,
  output logic               jtag_trst_no,
  input  logic               jtag_tdo_i
);

  typedef enum logic [2:0] {IDLE, PRE, SHIFT, POST, RSP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [1:0] CMD_RST  = 2'd0;
  localparam logic [1:0] CMD_IR   = 2'd1;
  localparam logic [1:0] CMD_BAD  = 2'd3;

  state_t               r_state;
  state_t               w_state_next;
  logic [6:0]           r_cnt;
  logic [6:0]           w_cnt_next;
  logic [7:0]           r_div;
  logic                 r_tck;
  logic                 r_tms;
  logic                 r_tdi;
  logic                 r_trst_n;
  logic                 r_err;
  logic                 r_is_rst;
  logic [6:0]           r_len;
  logic [6:0]           r_pre_last;
  logic [3:0]           r_pat;
  logic [MAX_LEN-1:0]   r_tx;
  logic [MAX_LEN-1:0]   r_cap;
  logic [MAX_LEN-1:0]   r_rsp_data;

  logic                 w_active;
  logic                 w_div_end;
  logic                 w_rise;
  logic                 w_cyc_end;
  logic                 w_accept;
  logic                 w_cmd_bad;
  logic [6:0]           w_post_last;

  assign w_active    = (r_state == PRE) || (r_state == SHIFT) || (r_state == POST);
  assign w_div_end   = (r_div == DIV_LAST);
  assign w_rise      = w_active && !r_tck && w_div_end;
  assign w_cyc_end   = w_active && r_tck && w_div_end;
  assign w_accept    = (r_state == IDLE) && cmd_valid_i;
  assign w_cmd_bad   = (cmd_type_i == CMD_BAD) || (cmd_len_i == 7'd0) ||
                       (int'(cmd_len_i) > MAX_LEN);
  assign w_post_last = r_is_rst ? 7'd0 : 7'd1;

  // Handshake and TRST outputs are gated by rst_i so they read as reset values
  // while it is high and take their run values in the very first cycle after.
  assign cmd_ready_o  = (r_state == IDLE) && !rst_i;
  assign jtag_trst_no = r_trst_n && !rst_i;
  assign rsp_valid_o  = (r_state == RSP);
  assign rsp_err_o    = r_err;
  assign rsp_data_o   = r_rsp_data;
  assign jtag_tck_o   = r_tck;
  assign jtag_tms_o   = r_tms;
  assign jtag_tdi_o   = r_tdi;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= 7'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = w_cmd_bad ? RSP : PRE;
          w_cnt_next   = 7'd0;
        end
      end
      PRE: begin
        if (w_cyc_end) begin
          if (r_cnt == r_pre_last) begin
            w_state_next = r_is_rst ? POST : SHIFT;
            w_cnt_next   = 7'd0;
          end else begin
            w_cnt_next = r_cnt + 7'd1;
          end
        end
      end
      SHIFT: begin
        if (w_cyc_end) begin
          if (r_cnt == r_len - 7'd1) begin
            w_state_next = POST;
            w_cnt_next   = 7'd0;
          end else begin
            w_cnt_next = r_cnt + 7'd1;
          end
        end
      end
      POST: begin
        if (w_cyc_end) begin
          if (r_cnt == w_post_last) begin
            w_state_next = RSP;
            w_cnt_next   = 7'd0;
          end else begin
            w_cnt_next = r_cnt + 7'd1;
          end
        end
      end
      RSP: begin
        if (rsp_ready_i) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = 7'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_div      <= 8'd0;
      r_tck      <= 1'b0;
      r_tms      <= 1'b1;
      r_tdi      <= 1'b0;
      r_trst_n   <= 1'b1;
      r_err      <= 1'b0;
      r_is_rst   <= 1'b0;
      r_len      <= 7'd0;
      r_pre_last <= 7'd0;
      r_pat      <= 4'd0;
      r_tx       <= '0;
      r_cap      <= '0;
      r_rsp_data <= '0;
    end else begin
      if (w_active) begin
        if (w_div_end) begin
          r_div <= 8'd0;
          r_tck <= ~r_tck;
        end else begin
          r_div <= r_div + 8'd1;
        end
      end

      // TDO enters at the top so the first sample ends up lowest after realignment.
      if (w_rise && (r_state == SHIFT)) begin
        r_cap <= {jtag_tdo_i, r_cap[MAX_LEN-1:1]};
      end

      if (w_accept) begin
        r_rsp_data <= '0;
        r_cap      <= '0;
        r_tx       <= cmd_data_i;
        r_len      <= cmd_len_i;
        r_is_rst   <= (cmd_type_i == CMD_RST);
        r_err      <= w_cmd_bad;
        r_div      <= 8'd0;
        r_tck      <= 1'b0;
        if (!w_cmd_bad) begin
          // First PRE bit is 1 for every command; r_pat holds the remaining PRE bits.
          r_tms    <= 1'b1;
          r_trst_n <= (cmd_type_i != CMD_RST);
          if (cmd_type_i == CMD_RST) begin
            r_pat      <= 4'b1111;
            r_pre_last <= 7'd4;
          end else if (cmd_type_i == CMD_IR) begin
            r_pat      <= 4'b0001;
            r_pre_last <= 7'd3;
          end else begin
            r_pat      <= 4'b0000;
            r_pre_last <= 7'd2;
          end
        end
      end

      if (w_cyc_end) begin
        case (w_state_next)
          PRE: begin
            r_tms <= r_pat[0];
            r_pat <= {1'b0, r_pat[3:1]};
          end
          SHIFT: begin
            r_tms <= (w_cnt_next == r_len - 7'd1);
            r_tdi <= r_tx[0];
            r_tx  <= {1'b0, r_tx[MAX_LEN-1:1]};
          end
          POST: begin
            r_tms    <= !r_is_rst && (w_cnt_next == 7'd0);
            r_tdi    <= 1'b0;
            r_trst_n <= 1'b1;
          end
          default: begin
            r_tdi      <= 1'b0;
            r_rsp_data <= r_is_rst ? '0 : (r_cap >> (MAX_LEN - int'(r_len)));
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtag_shift_master.sv
// Bench for jtag_shift_master: drives commands against a behavioural TAP
// (IDCODE/BYPASS) and compares scoreboarded responses with assertions.
`timescale 1ns/1ps
module tb_jtag_shift_master;
  localparam int          CLK_DIV    = 2;
  localparam int          MAX_LEN    = 64;
  localparam logic [31:0] IDCODE_VAL = 32'h4BA0_0477;
  localparam logic [4:0]  OP_IDCODE  = 5'h01;
  localparam logic [4:0]  OP_BYPASS  = 5'h1F;

  typedef enum logic [3:0] {
    T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PADR, T_EX2DR, T_UPDR,
    T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PAIR, T_EX2IR, T_UPIR
  } tap_t;

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          tck;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_type;
  logic [6:0]  cmd_len;
  logic [63:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_err;
  logic        jtag_tck;
  logic        jtag_tms;
  logic        jtag_tdi;
  logic        jtag_trst_n;
  logic        jtag_tdo;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        sb_q[$];

  tap_t        tap_state = T_TLR;
  logic [4:0]  tap_ir    = OP_IDCODE;
  logic [4:0]  ir_sr     = 5'd0;
  logic [31:0] dr_sr     = 32'd0;
  logic        tap_tdo   = 1'b0;
  int          tck_rises   = 0;
  int          tck_hi_cyc  = 0;
  int          trst_lo_cyc = 0;
  logic [63:0] tms_hist    = 64'd0;

  always #5 clk = ~clk;

  jtag_shift_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_type_i   (cmd_type),
    .cmd_len_i    (cmd_len),
    .cmd_data_i   (cmd_data),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_data_o   (rsp_data),
    .rsp_err_o    (rsp_err),
    .jtag_tck_o   (jtag_tck),
    .jtag_tms_o   (jtag_tms),
    .jtag_tdi_o   (jtag_tdi),
    .jtag_trst_no (jtag_trst_n),
    .jtag_tdo_i   (jtag_tdo)
  );

  function automatic tap_t tap_next(tap_t s, logic tms);
    case (s)
      T_TLR:   return tms ? T_TLR   : T_RTI;
      T_RTI:   return tms ? T_SELDR : T_RTI;
      T_SELDR: return tms ? T_SELIR : T_CAPDR;
      T_CAPDR: return tms ? T_EX1DR : T_SHDR;
      T_SHDR:  return tms ? T_EX1DR : T_SHDR;
      T_EX1DR: return tms ? T_UPDR  : T_PADR;
      T_PADR:  return tms ? T_EX2DR : T_PADR;
      T_EX2DR: return tms ? T_UPDR  : T_SHDR;
      T_UPDR:  return tms ? T_SELDR : T_RTI;
      T_SELIR: return tms ? T_TLR   : T_CAPIR;
      T_CAPIR: return tms ? T_EX1IR : T_SHIR;
      T_SHIR:  return tms ? T_EX1IR : T_SHIR;
      T_EX1IR: return tms ? T_UPIR  : T_PAIR;
      T_PAIR:  return tms ? T_EX2IR : T_PAIR;
      T_EX2IR: return tms ? T_UPIR  : T_SHIR;
      default: return tms ? T_SELDR : T_RTI;
    endcase
  endfunction

  // Behavioural target TAP: 5-bit IR, IDCODE and BYPASS data registers.
  always @(posedge jtag_tck or negedge jtag_trst_n) begin
    if (!jtag_trst_n) begin
      tap_state <= T_TLR;
      tap_ir    <= OP_IDCODE;
    end else begin
      case (tap_state)
        T_TLR:   tap_ir <= OP_IDCODE;
        T_CAPDR: dr_sr  <= (tap_ir == OP_IDCODE) ? IDCODE_VAL : 32'd0;
        T_SHDR:  dr_sr  <= (tap_ir == OP_IDCODE) ? {jtag_tdi, dr_sr[31:1]} : {31'd0, jtag_tdi};
        T_CAPIR: ir_sr  <= 5'b00001;
        T_SHIR:  ir_sr  <= {jtag_tdi, ir_sr[4:1]};
        T_UPIR:  tap_ir <= ir_sr;
        default: ;
      endcase
      tap_state <= tap_next(tap_state, jtag_tms);
    end
  end

  always @(negedge jtag_tck) begin
    tap_tdo <= (tap_state == T_SHDR) ? dr_sr[0] : ((tap_state == T_SHIR) ? ir_sr[0] : 1'b0);
  end
  assign jtag_tdo = tap_tdo;

  always @(posedge jtag_tck) begin
    tck_rises <= tck_rises + 1;
    tms_hist  <= {tms_hist[62:0], jtag_tms};
  end

  always @(negedge clk) begin
    if (jtag_tck)     tck_hi_cyc  <= tck_hi_cyc + 1;
    if (!jtag_trst_n) trst_lo_cyc <= trst_lo_cyc + 1;
  end

  function automatic logic [63:0] bypass_exp(logic [63:0] d, int len);
    logic [63:0] m;
    m = (len >= 64) ? '1 : ((64'd1 << len) - 64'd1);
    return (d << 1) & m;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, 64'({cmd_ready, rsp_valid, rsp_err, (rsp_data != 64'd0), jtag_tck,
                    jtag_tms, jtag_tdi, jtag_trst_n}), 64'(8'b0000_0100));
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] t, input logic [6:0] len,
                         input logic [63:0] data, input logic [63:0] exp_data,
                         input logic exp_err, input int exp_tck, input int hold);
    exp_t        e;
    exp_t        got;
    int          rise0;
    bit          ok;
    bit          stable;
    logic [63:0] d0;
    logic        e0;
    e.data = exp_data;
    e.err  = exp_err;
    e.tck  = exp_tck;
    sb_q.push_back(e);
    cmd_type  = t;
    cmd_len   = len;
    cmd_data  = data;
    cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    rise0 = tck_rises;
    @(negedge clk);
    cmd_valid = 1'b0;
    check({tag, "_accept"}, 64'(ok), 64'd1);
    if (exp_err) check({tag, "_rsp_next_cycle"}, 64'(rsp_valid), 64'd1);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_rsp_seen"}, 64'(ok), 64'd1);
    if (hold > 0) begin
      d0        = rsp_data;
      e0        = rsp_err;
      stable    = 1'b1;
      cmd_type  = 2'd2;
      cmd_len   = 7'd8;
      cmd_data  = 64'h55;
      cmd_valid = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (!(rsp_valid === 1'b1 && rsp_data === d0 && rsp_err === e0 && cmd_ready === 1'b0))
          stable = 1'b0;
      end
      cmd_valid = 1'b0;
      check({tag, "_hold_stable"}, 64'(stable), 64'd1);
    end
    got = sb_q.pop_front();
    $display("[TB] %s: rsp_data=%h err=%0d tck=%0d", tag, rsp_data, rsp_err, tck_rises - rise0);
    check({tag, "_data"}, rsp_data, got.data);
    check({tag, "_err"}, 64'(rsp_err), 64'(got.err));
    check({tag, "_tck"}, 64'(tck_rises - rise0), 64'(got.tck));
    if (!got.err) check({tag, "_tap_rti"}, 64'(tap_state), 64'(T_RTI));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_done"}, 64'({rsp_valid, cmd_ready}), 64'(2'b01));
  endtask

  task automatic run_tap_reset(input string tag);
    int hi0;
    int lo0;
    hi0 = tck_hi_cyc;
    lo0 = trst_lo_cyc;
    run_cmd(tag, 2'd0, 7'd8, 64'hFFFF, 64'd0, 1'b0, 6, 0);
    check({tag, "_tck_hi_cycles"}, 64'(tck_hi_cyc - hi0), 64'(6 * CLK_DIV));
    check({tag, "_trst_lo_cycles"}, 64'(trst_lo_cyc - lo0), 64'(5 * 2 * CLK_DIV));
    check({tag, "_tms_seq"}, 64'(tms_hist[5:0]), 64'(6'b111110));
  endtask

  initial begin
    logic [63:0] d;
    bit          ok;
    bit          quiet;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_type  = 2'd0;
    cmd_len   = 7'd0;
    cmd_data  = 64'd0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b0;
    #1;
    check("after_reset", 64'({cmd_ready, jtag_trst_n}), 64'(2'b11));
    @(negedge clk);

    run_tap_reset("tap_reset");
    run_cmd("ir_idcode", 2'd1, 7'd5, 64'(OP_IDCODE), 64'h1, 1'b0, 11, 0);
    run_cmd("dr_idcode", 2'd2, 7'd32, 64'd0, 64'(IDCODE_VAL), 1'b0, 37, 0);
    run_cmd("ir_bypass", 2'd1, 7'd5, 64'(OP_BYPASS), 64'h1, 1'b0, 11, 0);
    run_cmd("dr_bypass_a5", 2'd2, 7'd8, 64'hA5, 64'h4A, 1'b0, 13, 0);
    d = {$urandom, $urandom};
    run_cmd("dr_bypass_64", 2'd2, 7'd64, d, bypass_exp(d, 64), 1'b0, 69, 0);
    run_cmd("dr_bypass_1", 2'd2, 7'd1, 64'h1, 64'h0, 1'b0, 6, 0);
    d = {$urandom, $urandom};
    run_cmd("dr_bypass_17", 2'd2, 7'd17, d, bypass_exp(d, 17), 1'b0, 22, 0);
    run_cmd("err_type3", 2'd3, 7'd8, 64'hFF, 64'd0, 1'b1, 0, 0);
    run_cmd("err_len0", 2'd2, 7'd0, 64'hFF, 64'd0, 1'b1, 0, 0);
    run_cmd("err_len65", 2'd1, 7'd65, 64'hFF, 64'd0, 1'b1, 0, 0);
    run_cmd("hold_rsp", 2'd2, 7'd8, 64'h3C, 64'h78, 1'b0, 13, 50);
    run_cmd("after_hold", 2'd2, 7'd8, 64'hC3, 64'h86, 1'b0, 13, 0);

    cmd_type  = 2'd2;
    cmd_len   = 7'd64;
    cmd_data  = {$urandom, $urandom};
    cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    check("abort_accept", 64'(ok), 64'd1);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort_reset_state");
    rst = 1'b0;
    #1;
    check("abort_after_reset", 64'({cmd_ready, jtag_trst_n}), 64'(2'b11));
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || jtag_tck !== 1'b0) quiet = 1'b0;
    end
    check("abort_no_response", 64'(quiet), 64'd1);

    run_tap_reset("tap_reset2");
    run_cmd("ir_bypass2", 2'd1, 7'd5, 64'(OP_BYPASS), 64'h1, 1'b0, 11, 0);
    run_cmd("dr_bypass_a5_2", 2'd2, 7'd8, 64'hA5, 64'h4A, 1'b0, 13, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
